muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit for the EX stage of the pipelined core. It runs alongside the single-cycle ALU.
- Accepts operands, funct3 and a destination-register tag through a valid/ready handshake. Returns the result with a one-cycle done pulse.
- Holds `busy` high while computing so the hazard logic can stall F/D/E.
- Generalises the EX-stage arithmetic in width and iteration rate, and adds abort-on-flush behaviour.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and the iteration-count helper.
package muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Number of CALC cycles needed to retire all WIDTH bits.
    function automatic int calc_iters(input int width, input int step);
        return width / step;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One CALC iteration: STEP shift-add (multiply) or restoring shift-subtract
// (divide) steps over the 2*WIDTH accumulator, purely combinational.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_v;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     sum;

    // Multiply: {hi, lo} with the multiplier in lo; add the multiplicand into hi
    // when lo[0] is set, then shift right keeping the carry.
    // Divide: {rem, quo} with the dividend in quo; shift left, trial-subtract.
    // NOTE: every variable written in this always_comb is assigned a default
    // first, so no path can leave a value held and infer a latch.
    always_comb begin
        acc_v   = acc_i;
        shifted = '0;
        diff    = '0;
        sum     = '0;
        for (int i = 0; i < STEP; i++) begin
            if (div_i) begin
                shifted = {acc_v[2*WIDTH-1:WIDTH], acc_v[WIDTH-1]};
                diff    = shifted - {1'b0, opd_i};
                if (!diff[WIDTH]) begin
                    acc_v = {diff[WIDTH-1:0], acc_v[WIDTH-2:0], 1'b1};
                end else begin
                    acc_v = {shifted[WIDTH-1:0], acc_v[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum   = {1'b0, acc_v[2*WIDTH-1:WIDTH]} + (acc_v[0] ? {1'b0, opd_i} : '0);
                acc_v = {sum, acc_v[WIDTH-1:1]};
            end
        end
        acc_o = acc_v;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: valid/ready accept,
// CALC iterations, FIX sign correction, one-cycle done pulse, flush abort.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int N     = calc_iters(WIDTH, STEP);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   opd_q;
    logic [2:0]         op_q;
    logic [TAG_W-1:0]   tag_q;
    logic               neg_q, rem_neg_q, special_q;
    logic [WIDTH-1:0]   result_q;
    logic [TAG_W-1:0]   tag_out_q;

    // Operand decode at accept time.
    logic             accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic             div_zero, overflow, special;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;

    assign ready_out = (state_q == S_IDLE);
    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign tag_out   = tag_out_q;
    assign accept    = valid_in && ready_out && !flush;

    assign is_div   = op[2];
    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign a_neg    = a_signed && a[WIDTH-1];
    assign b_neg    = b_signed && b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;

    // op[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
    assign div_zero = is_div && (b == '0);
    assign overflow = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    assign special  = div_zero || overflow;
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? a : '1;
        end else if (overflow) begin
            special_res = op[1] ? '0 : a;
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .div_i (op_q[2]),
        .acc_i (acc_q),
        .opd_i (opd_q),
        .acc_o (acc_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_FIX : S_CALC;
                    cnt_d   = CNT_LAST;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush && busy) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: operand/accumulator registers are deliberately not reset; they are
    // always loaded on accept before being read, so a reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= op;
            tag_q     <= tag_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            special_q <= special;
            opd_q     <= is_div ? b_mag : a_mag;
            if (special) begin
                acc_q <= {{WIDTH{1'b0}}, special_res};
            end else begin
                acc_q <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
            end
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
        end
    end

    // FIX: sign correction and output selection.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_res;
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_res = '0;
        if (special_q) begin
            fix_res = acc_q[WIDTH-1:0];
        end else if (op_q == OP_MUL) begin
            fix_res = prod[WIDTH-1:0];
        end else if (!op_q[2]) begin
            fix_res = prod[2*WIDTH-1:WIDTH];
        end else if (!op_q[1]) begin
            fix_res = neg_q ? -quo : quo;
        end else begin
            fix_res = rem_neg_q ? -rem : rem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q  <= '0;
            tag_out_q <= '0;
        end else if ((state_q == S_FIX) && !flush) begin
            result_q  <= fix_res;
            tag_out_q <= tag_q;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a STEP=1 and a STEP=4 instance share the
// stimulus; results, latencies, busy/ready, flush and reset are checked.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  tag_in = '0;

    logic        rdy1, busy1, done1, rdy4, busy4, done4;
    logic [31:0] res1, res4;
    logic [4:0]  tago1, tago4;

    int n_pass = 0;
    int n_total = 0;
    int lat1, lat4, busy_cnt, rdy_cnt, extra_done;
    logic [31:0] r1, r4;
    logic [4:0]  t1;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .STEP(1), .TAG_W(5)) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(rdy1),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .flush(flush),
        .busy(busy1), .done(done1), .result(res1), .tag_out(tago1)
    );

    muldiv_unit #(.WIDTH(32), .STEP(4), .TAG_W(5)) dut4 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(rdy4),
        .op(op), .a(a), .b(b), .tag_in(tag_in), .flush(flush),
        .busy(busy4), .done(done4), .result(res4), .tag_out(tago4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge with both units idle; returns one cycle after the
    // slower unit's done pulse, so both are back in IDLE.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] t);
        op = o; a = x; b = y; tag_in = t; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat1 = 0; lat4 = 0; busy_cnt = 0; rdy_cnt = 0;
        r1 = 'x; r4 = 'x; t1 = 'x;
        for (int n = 1; n <= 60 && (lat1 == 0 || lat4 == 0); n++) begin
            if (n > 1) @(negedge clk);
            if (lat1 == 0 && busy1) busy_cnt++;
            if (lat1 == 0 && rdy1) rdy_cnt++;
            if (lat1 == 0 && done1) begin lat1 = n; r1 = res1; t1 = tago1; end
            if (lat4 == 0 && done4) begin lat4 = n; r4 = res4; end
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_ready", 32'(rdy1), 32'd1);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_result", res1, 32'h0);
        check("rst_tag", 32'(tago1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MUL 7 * -3
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
        check("mul_res", r1, 32'hFFFF_FFEB);
        check("mul_lat", 32'(lat1), 32'd34);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
        check("mul_ready_low", 32'(rdy_cnt), 32'd0);
        check("mul_res_s4", r4, 32'hFFFF_FFEB);
        check("mul_lat_s4", 32'(lat4), 32'd10);
        check("mul_held", res1, 32'hFFFF_FFEB);

        // High-half multiplies
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        check("mulh_res", r1, 32'h0000_0000);
        check("mulh_tag", 32'(t1), 32'd12);
        check("mulh_res_s4", r4, 32'h0000_0000);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        check("mulhsu_res", r1, 32'h8000_0000);
        check("mulhsu_res_s4", r4, 32'h8000_0000);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        check("mulhu_res", r1, 32'h7FFF_FFFF);
        check("mulhu_tag", 32'(t1), 32'd13);
        check("mulhu_res_s4", r4, 32'h7FFF_FFFF);

        // Divide / remainder
        run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd2);
        check("div_res", r1, 32'hFFFF_FFFA);
        check("div_lat", 32'(lat1), 32'd34);
        check("div_res_s4", r4, 32'hFFFF_FFFA);
        check("div_lat_s4", 32'(lat4), 32'd10);
        run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd3);
        check("rem_res", r1, 32'hFFFF_FFFE);
        check("rem_res_s4", r4, 32'hFFFF_FFFE);
        run_op(3'd5, 32'd20, 32'd3, 5'd4);
        check("divu_res", r1, 32'd6);
        check("divu_res_s4", r4, 32'd6);
        run_op(3'd7, 32'd20, 32'd3, 5'd5);
        check("remu_res", r1, 32'd2);
        check("remu_res_s4", r4, 32'd2);

        // Special cases
        run_op(3'd5, 32'd5, 32'd0, 5'd6);
        check("divu0_res", r1, 32'hFFFF_FFFF);
        check("divu0_lat", 32'(lat1), 32'd2);
        check("divu0_busy", 32'(busy_cnt), 32'd1);
        run_op(3'd6, 32'd5, 32'd0, 5'd7);
        check("rem0_res", r1, 32'd5);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        check("rem_ovf_res", r1, 32'd0);
        check("rem_ovf_lat", 32'(lat1), 32'd2);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        check("div_ovf_res", r1, 32'h8000_0000);
        check("div_ovf_tag", 32'(t1), 32'd9);

        // Flush in IDLE blocks the same-cycle request
        op = 3'd4; a = 32'd100; b = 32'd7; tag_in = 5'd10;
        valid_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid_in = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 32'(busy1), 32'd0);
        check("idle_flush_ready", 32'(rdy1), 32'd1);

        // Flush during CALC of a DIV
        op = 3'd4; a = 32'hFFFF_FFEC; b = 32'd3; tag_in = 5'd11; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (8) @(negedge clk);
        check("pre_flush_busy", 32'(busy1), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_ready", 32'(rdy1), 32'd1);
        check("flush_idle_busy", 32'(busy1), 32'd0);
        extra_done = 0;
        for (int n = 0; n < 40; n++) begin
            if (done1) extra_done++;
            @(negedge clk);
        end
        check("flush_no_done", 32'(extra_done), 32'd0);
        check("flush_res_kept", res1, 32'h8000_0000);
        check("flush_tag_kept", 32'(tago1), 32'd9);

        // Reset asserted mid-CALC
        op = 3'd0; a = 32'd9; b = 32'd9; tag_in = 5'd14; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        check("midrst_ready", 32'(rdy1), 32'd1);
        check("midrst_result", res1, 32'h0);
        check("midrst_tag", 32'(tago1), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Unit still works after reset
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        check("post_rst_mulhu", r1, 32'h7FFF_FFFF);
        check("post_rst_lat", 32'(lat1), 32'd34);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
